app_mfb_pkt_rr_arbiter: RTL and testbench
=========================================

Name: app_mfb_pkt_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one application TX stream (e.g. one ETH TX port) between INPUTS requesters (e.g. DMA streams).
- Interface is single-region, MFB-style: SOF/EOF word stream with SRC_RDY/DST_RDY.
- A grant is held from SOF to EOF, so packets are never interleaved.
- Output is registered (one pipeline stage), with full backpressure and a source-index sideband for downstream header insertion.

Parameters:
- INPUTS, 4, number of requesting streams (≥2).
- DATA_WIDTH, 512, data word width in bits.
- SEL_WIDTH, max(1,$clog2(INPUTS)), width of source index.

Ports:
- CLK  in  1  clock
- RESET_N  in  1  asynchronous active-low reset
- RX_DATA  in  INPUTS*DATA_WIDTH  input words; input i at [i*DATA_WIDTH +: DATA_WIDTH]
- RX_SOF  in  INPUTS  start of packet per input
- RX_EOF  in  INPUTS  end of packet per input
- RX_SRC_RDY  in  INPUTS  word valid per input
- RX_DST_RDY  out  INPUTS  word accepted per input
- TX_DATA  out  DATA_WIDTH  output word
- TX_SOF  out  1  start of packet
- TX_EOF  out  1  end of packet
- TX_SEL  out  SEL_WIDTH  index of input that owns the current word
- TX_SRC_RDY  out  1  output valid
- TX_DST_RDY  in  1  output accepted
- ERR_PROTO  out  1  sticky protocol-error flag

Behaviour:
- Reset (RESET_N=0, async):
  - TX_SRC_RDY=0, TX_SOF=0, TX_EOF=0, TX_SEL=0, TX_DATA=0, ERR_PROTO=0.
  - State=IDLE, last_grant=INPUTS-1, so input 0 has first priority.
  - RX_DST_RDY=0 while in reset.
- Output register:
  - can_load = !TX_SRC_RDY | TX_DST_RDY.
  - A word transfers on the RX side when RX_SRC_RDY[g] & RX_DST_RDY[g], and is visible on TX the next cycle.
  - The TX register holds its value while TX_SRC_RDY & !TX_DST_RDY.
  - TX_SRC_RDY is cleared after a TX transfer when no new word is loaded.
- RX_DST_RDY[i] = can_load & (i == current grant). Only one bit is ever set; no combinational path from RX_SRC_RDY to RX_DST_RDY in LOCKED state.
- State machine:
  - IDLE:
    - Winner = first i with RX_SRC_RDY[i], scanning from last_grant+1 with modulo-INPUTS wrap.
    - The grant is combinational in the same cycle. If can_load, the winner's word is accepted that cycle.
    - On acceptance, last_grant <= winner.
    - If the accepted word has EOF=1 (single-word packet), stay in IDLE. Otherwise go to LOCKED with lock_idx=winner.
    - If !can_load, no word is accepted and last_grant is unchanged.
  - LOCKED:
    - Grant = lock_idx only; all other inputs see RX_DST_RDY=0.
    - On acceptance of a word with EOF=1, return to IDLE.
    - Round-robin resumes from lock_idx+1 in the next cycle.
- Arbitration latency: 0 cycles from request to grant in IDLE. Zero idle cycles between back-to-back packets from different inputs.
- Fairness: with all inputs continuously requesting, grants go 0,1,…,INPUTS-1,0,… per packet.
- TX_SEL equals the owning input index for every word of the packet.
- Protocol checks. ERR_PROTO is set, and stays set until reset, if either:
  - a word accepted in IDLE has SOF=0;
  - a word accepted in LOCKED has SOF=1.
- Data forwarding on error: the offending word is still forwarded unchanged. FSM transitions follow EOF only.
- Inputs whose RX_SRC_RDY drops mid-packet: the grant stays locked and TX stalls, i.e. TX_SRC_RDY=0 after drain. No timeout.
- Simultaneous events:
  - A TX transfer and a new RX load in the same cycle give a continuous stream at 1 word/cycle.
  - A request arriving in the same cycle as EOF acceptance is not considered until the next cycle, because the FSM is still LOCKED.

Test Plan:
- Reset then all 4 inputs continuously offer 3-word packets, TX_DST_RDY=1 → TX_SEL per packet 0,1,2,3,0; 12 consecutive valid TX cycles per round, no bubbles; TX_SOF/TX_EOF on words 1/3 of each packet.
- Only input 2 requests single-word packets (SOF=EOF=1) every cycle → TX_SRC_RDY=1 every cycle from cycle 1, TX_SEL=2, ERR_PROTO=0.
- Input 1 mid-packet (word 2 of 5) while input 0 requests; TX_DST_RDY held 0 for 4 cycles → TX word frozen, RX_DST_RDY=0 for all inputs; on release input 1 finishes 5 words before TX_SEL=0 appears.
- Input 3 sends word with SOF=0 in IDLE → word forwarded, ERR_PROTO=1 next cycle and remains 1; a subsequent SOF inside a packet also keeps ERR_PROTO=1.
- Assert RESET_N=0 asynchronously while input 0 locked mid-packet → TX_SRC_RDY=0 immediately; after release input 1 and input 0 both request → input 0 granted first (last_grant reset to 3).
- Random SRC_RDY/DST_RDY, INPUTS=3, 1000 packets → per-input packet order preserved, no interleaving within TX packets, data matches scoreboard.

Source files
------------

// File: rtl/app_mfb_pkt_rr_arbiter_if.sv
// MFB-style word stream bundle: INPUTS requester lanes on RX, one shared lane on TX.
interface app_mfb_pkt_rr_arbiter_if #(
    parameter int INPUTS     = 4,
    parameter int DATA_WIDTH = 512,
    parameter int SEL_WIDTH  = (INPUTS > 1) ? $clog2(INPUTS) : 1
);
    logic [INPUTS*DATA_WIDTH-1:0] RX_DATA;
    logic [INPUTS-1:0]            RX_SOF;
    logic [INPUTS-1:0]            RX_EOF;
    logic [INPUTS-1:0]            RX_SRC_RDY;
    logic [INPUTS-1:0]            RX_DST_RDY;
    logic [DATA_WIDTH-1:0]        TX_DATA;
    logic                         TX_SOF;
    logic                         TX_EOF;
    logic [SEL_WIDTH-1:0]         TX_SEL;
    logic                         TX_SRC_RDY;
    logic                         TX_DST_RDY;

    modport master (
        output RX_DATA, RX_SOF, RX_EOF, RX_SRC_RDY, TX_DST_RDY,
        input  RX_DST_RDY, TX_DATA, TX_SOF, TX_EOF, TX_SEL, TX_SRC_RDY
    );

    modport slave (
        input  RX_DATA, RX_SOF, RX_EOF, RX_SRC_RDY, TX_DST_RDY,
        output RX_DST_RDY, TX_DATA, TX_SOF, TX_EOF, TX_SEL, TX_SRC_RDY
    );
endinterface

// File: rtl/app_mfb_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter onto one MFB TX stream; 1-cycle registered output.
// Grant is combinational in IDLE; RX_DST_RDY follows TX_DST_RDY through the output register.
module app_mfb_pkt_rr_arbiter #(
    parameter int INPUTS     = 4,
    parameter int DATA_WIDTH = 512,
    parameter int SEL_WIDTH  = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    app_mfb_pkt_rr_arbiter_if.slave  bus,
    output logic                     ERR_PROTO
);
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [SEL_WIDTH-1:0]  last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [SEL_WIDTH-1:0]  tx_sel_q, tx_sel_d;
    logic                  tx_sof_q, tx_sof_d;
    logic                  tx_eof_q, tx_eof_d;
    logic                  tx_vld_q, tx_vld_d;
    logic                  err_q, err_d;

    logic                  can_load, hi_vld, lo_vld, gnt_vld;
    logic                  gnt_req, gnt_sof, gnt_eof, xfer;
    logic [SEL_WIDTH-1:0]  hi_idx, lo_idx, gnt_idx;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic [INPUTS-1:0]     rx_dst_rdy;

    // last_grant doubles as the lock index: it is set to the winner on the SOF word.
    always_comb begin
        can_load = !tx_vld_q || bus.TX_DST_RDY;
        hi_vld   = 1'b0;
        lo_vld   = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < INPUTS; i++) begin
            if (bus.RX_SRC_RDY[i]) begin
                if (SEL_WIDTH'(i) > last_grant_q) begin
                    if (!hi_vld) begin
                        hi_vld = 1'b1;
                        hi_idx = SEL_WIDTH'(i);
                    end
                end else if (!lo_vld) begin
                    lo_vld = 1'b1;
                    lo_idx = SEL_WIDTH'(i);
                end
            end
        end
        if (state_q == LOCKED) begin
            gnt_vld = 1'b1;
            gnt_idx = last_grant_q;
        end else begin
            gnt_vld = hi_vld || lo_vld;
            gnt_idx = hi_vld ? hi_idx : lo_idx;
        end
        gnt_req    = 1'b0;
        gnt_sof    = 1'b0;
        gnt_eof    = 1'b0;
        gnt_data   = '0;
        rx_dst_rdy = '0;
        for (int i = 0; i < INPUTS; i++) begin
            if (SEL_WIDTH'(i) == gnt_idx) begin
                gnt_req       = bus.RX_SRC_RDY[i];
                gnt_sof       = bus.RX_SOF[i];
                gnt_eof       = bus.RX_EOF[i];
                gnt_data      = bus.RX_DATA[i*DATA_WIDTH +: DATA_WIDTH];
                rx_dst_rdy[i] = can_load && gnt_vld && RESET_N;
            end
        end
        xfer = gnt_req && can_load && gnt_vld && RESET_N;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        err_d        = err_q;
        tx_data_d    = tx_data_q;
        tx_sel_d     = tx_sel_q;
        tx_sof_d     = tx_sof_q;
        tx_eof_d     = tx_eof_q;
        tx_vld_d     = tx_vld_q && !bus.TX_DST_RDY;
        if (xfer) begin
            tx_vld_d     = 1'b1;
            tx_data_d    = gnt_data;
            tx_sel_d     = gnt_idx;
            tx_sof_d     = gnt_sof;
            tx_eof_d     = gnt_eof;
            last_grant_d = gnt_idx;
            // Protocol errors are flagged only; the FSM still tracks EOF alone.
            if (state_q == IDLE) begin
                err_d   = err_q || !gnt_sof;
                state_d = gnt_eof ? IDLE : LOCKED;
            end else begin
                err_d   = err_q || gnt_sof;
                state_d = gnt_eof ? IDLE : LOCKED;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            last_grant_q <= SEL_WIDTH'(INPUTS - 1);
            err_q        <= 1'b0;
            tx_data_q    <= '0;
            tx_sel_q     <= '0;
            tx_sof_q     <= 1'b0;
            tx_eof_q     <= 1'b0;
            tx_vld_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
            tx_data_q    <= tx_data_d;
            tx_sel_q     <= tx_sel_d;
            tx_sof_q     <= tx_sof_d;
            tx_eof_q     <= tx_eof_d;
            tx_vld_q     <= tx_vld_d;
        end
    end

    assign bus.RX_DST_RDY = rx_dst_rdy;
    assign bus.TX_DATA    = tx_data_q;
    assign bus.TX_SEL     = tx_sel_q;
    assign bus.TX_SOF     = tx_sof_q;
    assign bus.TX_EOF     = tx_eof_q;
    assign bus.TX_SRC_RDY = tx_vld_q;
    assign ERR_PROTO      = err_q;
endmodule

// File: tb/tb_app_mfb_pkt_rr_arbiter.sv
// Bench for app_mfb_pkt_rr_arbiter: grant table, directed packet sequences, random scoreboard run.
module tb_app_mfb_pkt_rr_arbiter;
    localparam int NI = 4;
    localparam int DW = 32;
    localparam int SW = 2;

    typedef struct packed {
        logic          sof;
        logic          eof;
        logic [DW-1:0] dat;
    } word_t;

    typedef struct {
        logic [NI-1:0] req;
        logic          dr;
        logic [NI-1:0] exp_dst;
        logic          exp_vld;
        logic [SW-1:0] exp_sel;
    } vec_t;

    logic CLK;
    logic RESET_N;
    logic ERR_PROTO;

    app_mfb_pkt_rr_arbiter_if #(.INPUTS(NI), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus ();

    app_mfb_pkt_rr_arbiter #(.INPUTS(NI), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .bus       (bus),
        .ERR_PROTO (ERR_PROTO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int      nvec = 0;
    int      nerr = 0;
    word_t   src_q[NI][$];
    word_t   exp_q[NI][$];
    int      accepted[NI];
    int      pkt_cnt[NI];
    int      sof_log[$];
    bit [NI-1:0] en;
    bit      rnd_src;
    int      dst_mode;
    bit      in_pkt;
    int      cur_sel;
    bit      bub_on;
    bit      seen_vld;
    int      bubbles;
    int      tx_words;
    vec_t    tbl[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NI; i++)
            if (exp_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_inputs();
        bus.RX_SRC_RDY = '0;
        bus.RX_SOF     = '0;
        bus.RX_EOF     = '0;
        bus.RX_DATA    = '0;
        bus.TX_DST_RDY = 1'b0;
    endtask

    task automatic clear_state();
        for (int i = 0; i < NI; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
            accepted[i] = 0;
        end
        sof_log.delete();
        in_pkt   = 1'b0;
        bub_on   = 1'b0;
        seen_vld = 1'b0;
        bubbles  = 0;
        tx_words = 0;
        en       = '0;
        rnd_src  = 1'b0;
        dst_mode = 1;
    endtask

    task automatic reset_dut();
        RESET_N = 1'b0;
        clear_inputs();
        clear_state();
        @(posedge CLK);
        @(posedge CLK);
        #3;
        RESET_N = 1'b1;
    endtask

    // Word data encodes input, per-input packet number and word index.
    task automatic add_pkt(input int i, input int len, input bit first_sof, input int extra_sof);
        word_t w;
        for (int k = 0; k < len; k++) begin
            w.sof = (k == 0) ? first_sof : (k == extra_sof);
            w.eof = (k == len - 1);
            w.dat = (32'(i) << 28) | (32'(pkt_cnt[i] & 32'hfff) << 16) | 32'(k);
            src_q[i].push_back(w);
            exp_q[i].push_back(w);
        end
        pkt_cnt[i]++;
    endtask

    task automatic drive();
        word_t w;
        for (int i = 0; i < NI; i++) begin
            if (en[i] && src_q[i].size() > 0 && (!rnd_src || $urandom_range(0, 3) != 0)) begin
                w = src_q[i][0];
                bus.RX_SRC_RDY[i]        = 1'b1;
                bus.RX_SOF[i]            = w.sof;
                bus.RX_EOF[i]            = w.eof;
                bus.RX_DATA[i*DW +: DW]  = w.dat;
            end else begin
                bus.RX_SRC_RDY[i] = 1'b0;
            end
        end
        case (dst_mode)
            0:       bus.TX_DST_RDY = 1'b0;
            1:       bus.TX_DST_RDY = 1'b1;
            default: bus.TX_DST_RDY = ($urandom_range(0, 2) != 0);
        endcase
    endtask

    task automatic sample();
        word_t got;
        word_t exp;
        int    s;
        check("rx_dst_onehot", ($countones(bus.RX_DST_RDY) <= 1), 1);
        for (int i = 0; i < NI; i++) begin
            if (bus.RX_SRC_RDY[i] && bus.RX_DST_RDY[i]) begin
                if (src_q[i].size() > 0) void'(src_q[i].pop_front());
                accepted[i]++;
            end
        end
        if (bub_on) begin
            if (bus.TX_SRC_RDY) seen_vld = 1'b1;
            else if (seen_vld && !all_empty()) bubbles++;
        end
        if (bus.TX_SRC_RDY && bus.TX_DST_RDY) begin
            s   = int'(bus.TX_SEL);
            got = '{sof: bus.TX_SOF, eof: bus.TX_EOF, dat: bus.TX_DATA};
            if (exp_q[s].size() == 0) begin
                check("sb_unexpected_word", got, 0);
            end else begin
                exp = exp_q[s].pop_front();
                check("sb_word", got, exp);
            end
            if (bus.TX_SOF) begin
                sof_log.push_back(s);
                cur_sel = s;
                in_pkt  = !bus.TX_EOF;
            end else if (in_pkt) begin
                check("no_interleave", s, cur_sel);
                if (bus.TX_EOF) in_pkt = 1'b0;
            end
            tx_words++;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        drive();
        @(negedge CLK);
        sample();
    endtask

    task automatic run_until_empty(input int budget, input string name);
        int n = 0;
        while (!all_empty() && n < budget) begin
            tick();
            n++;
        end
        check(name, all_empty(), 1);
        tick();
        tick();
    endtask

    task automatic wait_accept(input int i, input int n, input int budget, input string name);
        int c = 0;
        while (accepted[i] < n && c < budget) begin
            tick();
            c++;
        end
        check(name, (accepted[i] >= n), 1);
    endtask

    initial begin
        int frz_pkt;
        int total_words;
        logic [DW-1:0] frz;

        // Single-word packets on every input; grant decisions hand-derived from last_grant=3.
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
        tbl[2]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd1};
        tbl[3]  = '{4'b0101, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[4]  = '{4'b0101, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[5]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd2};
        tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
        tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[8]  = '{4'b1000, 1'b0, 4'b1000, 1'b0, 2'd0};
        tbl[9]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd3};
        tbl[10] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd3};
        tbl[11] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd0};
        tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3};

        for (int i = 0; i < NI; i++) pkt_cnt[i] = 0;
        clear_state();
        RESET_N = 1'b0;
        clear_inputs();
        bus.RX_SRC_RDY = '1;
        bus.RX_SOF     = '1;
        bus.TX_DST_RDY = 1'b1;
        #12;
        check("rst_tx_src_rdy", bus.TX_SRC_RDY, 0);
        check("rst_tx_sof", bus.TX_SOF, 0);
        check("rst_tx_eof", bus.TX_EOF, 0);
        check("rst_tx_sel", bus.TX_SEL, 0);
        check("rst_tx_data", bus.TX_DATA, 0);
        check("rst_err", ERR_PROTO, 0);
        check("rst_rx_dst_rdy", bus.RX_DST_RDY, 0);
        clear_inputs();
        @(posedge CLK);
        #3;
        RESET_N = 1'b1;

        for (int i = 0; i < NI; i++) bus.RX_DATA[i*DW +: DW] = 32'hD000_0000 | 32'(i);
        for (int v = 0; v < 13; v++) begin
            @(posedge CLK);
            #1;
            bus.RX_SRC_RDY = tbl[v].req;
            bus.RX_SOF     = '1;
            bus.RX_EOF     = '1;
            bus.TX_DST_RDY = tbl[v].dr;
            @(negedge CLK);
            check($sformatf("tbl%0d_rx_dst_rdy", v), bus.RX_DST_RDY, tbl[v].exp_dst);
            check($sformatf("tbl%0d_tx_src_rdy", v), bus.TX_SRC_RDY, tbl[v].exp_vld);
            if (tbl[v].exp_vld) begin
                check($sformatf("tbl%0d_tx_sel", v), bus.TX_SEL, tbl[v].exp_sel);
                check($sformatf("tbl%0d_tx_data", v), bus.TX_DATA, 32'hD000_0000 | 32'(tbl[v].exp_sel));
            end
        end
        check("tbl_err", ERR_PROTO, 0);

        // Fairness: all inputs, 3-word packets, two rounds, no bubbles.
        reset_dut();
        en = '1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NI; i++) add_pkt(i, 3, 1'b1, -1);
        bub_on = 1'b1;
        run_until_empty(200, "rr_drain");
        check("rr_bubbles", bubbles, 0);
        check("rr_words", tx_words, 24);
        check("rr_pkts", sof_log.size(), 8);
        if (sof_log.size() == 8)
            for (int k = 0; k < 8; k++) check($sformatf("rr_sel%0d", k), sof_log[k], k % NI);

        // Back-to-back single-word packets from input 2.
        reset_dut();
        en = 4'b0100;
        for (int k = 0; k < 8; k++) add_pkt(2, 1, 1'b1, -1);
        bub_on = 1'b1;
        run_until_empty(100, "single_drain");
        check("single_bubbles", bubbles, 0);
        check("single_words", tx_words, 8);
        foreach (sof_log[k]) check("single_sel", sof_log[k], 2);
        check("single_err", ERR_PROTO, 0);

        // Backpressure while input 1 is mid-packet and input 0 is waiting.
        reset_dut();
        en = 4'b0010;
        frz_pkt = pkt_cnt[1];
        add_pkt(1, 5, 1'b1, -1);
        add_pkt(0, 3, 1'b1, -1);
        frz = (32'd1 << 28) | (32'(frz_pkt & 32'hfff) << 16) | 32'd1;
        wait_accept(1, 2, 20, "bp_reach_word2");
        dst_mode = 0;
        en = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("bp_rx_dst_rdy%0d", k), bus.RX_DST_RDY, 0);
            check($sformatf("bp_tx_vld%0d", k), bus.TX_SRC_RDY, 1);
            check($sformatf("bp_tx_data%0d", k), bus.TX_DATA, frz);
        end
        dst_mode = 1;
        run_until_empty(100, "bp_drain");
        check("bp_pkts", sof_log.size(), 2);
        if (sof_log.size() == 2) begin
            check("bp_first", sof_log[0], 1);
            check("bp_second", sof_log[1], 0);
        end

        // Protocol errors: SOF missing in IDLE, then SOF repeated inside a packet.
        reset_dut();
        en = 4'b1000;
        add_pkt(3, 1, 1'b0, -1);
        wait_accept(3, 1, 10, "err_accept");
        check("err_before", ERR_PROTO, 0);
        tick();
        check("err_set", ERR_PROTO, 1);
        run_until_empty(50, "err_drain");
        add_pkt(3, 3, 1'b1, 1);
        run_until_empty(50, "err_drain2");
        check("err_sticky", ERR_PROTO, 1);
        reset_dut();
        check("err_cleared", ERR_PROTO, 0);
        en = 4'b0001;
        add_pkt(0, 3, 1'b1, 1);
        run_until_empty(50, "err_locked_drain");
        check("err_locked_sof", ERR_PROTO, 1);

        // Asynchronous reset with input 0 locked mid-packet.
        reset_dut();
        en = 4'b0001;
        add_pkt(0, 4, 1'b1, -1);
        wait_accept(0, 2, 20, "arst_reach");
        tick();
        check("arst_pre_vld", bus.TX_SRC_RDY, 1);
        #2;
        RESET_N = 1'b0;
        clear_inputs();
        #1;
        check("arst_tx_vld", bus.TX_SRC_RDY, 0);
        check("arst_rx_dst_rdy", bus.RX_DST_RDY, 0);
        clear_state();
        @(posedge CLK);
        @(posedge CLK);
        #3;
        RESET_N = 1'b1;
        en = 4'b0011;
        add_pkt(1, 3, 1'b1, -1);
        add_pkt(0, 3, 1'b1, -1);
        run_until_empty(50, "arst_drain");
        check("arst_pkts", sof_log.size(), 2);
        if (sof_log.size() == 2) begin
            check("arst_first", sof_log[0], 0);
            check("arst_second", sof_log[1], 1);
        end

        // Random valid/ready on three inputs, 1000 packets.
        reset_dut();
        en = 4'b0111;
        rnd_src = 1'b1;
        dst_mode = 2;
        total_words = 0;
        for (int p = 0; p < 1000; p++) begin
            int i;
            int len;
            i   = $urandom_range(0, 2);
            len = $urandom_range(1, 6);
            add_pkt(i, len, 1'b1, -1);
            total_words += len;
        end
        run_until_empty(40000, "rand_drain");
        check("rand_words", tx_words, total_words);
        check("rand_pkts", sof_log.size(), 1000);
        check("rand_err", ERR_PROTO, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
